// File: rtl/pe_feed_pkg.sv
// Shared definitions for the PE tile feeder: FSM state encoding and the
// operand/control widths that must match the PE wrapper.
package pe_feed_pkg;

  localparam int PE_A_W     = 8;
  localparam int PE_B_W     = 19;
  localparam int PE_D_W     = 19;
  localparam int PE_SHIFT_W = 4;
  localparam int PE_LEN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DONE    = 2'd3
  } feed_state_e;

endpackage

// File: rtl/pe_tile_feeder.sv
// Turns one tile command plus a stream of a/b operand beats into the PE input
// sequence: a preload beat carrying d, then K compute beats, with registered outputs.
module pe_tile_feeder
  import pe_feed_pkg::*;
#(
  parameter int A_W     = PE_A_W,
  parameter int B_W     = PE_B_W,
  parameter int D_W     = PE_D_W,
  parameter int SHIFT_W = PE_SHIFT_W,
  parameter int LEN_W   = PE_LEN_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [D_W-1:0]     cmd_d,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [A_W-1:0]     data_a,
  input  logic [B_W-1:0]     data_b,
  output logic [A_W-1:0]     io_in_a1,
  output logic [B_W-1:0]     io_in_b1,
  output logic [D_W-1:0]     io_in_d1,
  output logic               io_in_valid1,
  output logic [SHIFT_W-1:0] io_in_control_shift1,
  output logic               io_in_control_propagate1,
  output logic               tile_done,
  output logic               busy
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  feed_state_e        state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SHIFT_W-1:0] shift_lat_q, shift_lat_d;
  logic [D_W-1:0]     d_lat_q, d_lat_d;
  logic               prop_q, prop_d;
  logic [LEN_W:0]     count_q, count_d;
  logic [A_W-1:0]     a_q, a_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [D_W-1:0]     d_q, d_d;
  logic               valid_q, valid_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               prop_out_q, prop_out_d;
  logic               done_q, done_d;

  // Handshake readiness depends only on state/counter so senders see no loop.
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign data_ready = (state_q == ST_STREAM) && (count_q < {1'b0, len_q});

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    shift_lat_d = shift_lat_q;
    d_lat_d     = d_lat_q;
    prop_d      = prop_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    valid_d     = 1'b0;
    shift_d     = shift_q;
    prop_out_d  = prop_out_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d       = cmd_len;
          shift_lat_d = cmd_shift;
          d_lat_d     = cmd_d;
          prop_d      = ~prop_q;
          state_d     = ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        a_d        = '0;
        b_d        = '0;
        d_d        = d_lat_q;
        valid_d    = 1'b1;
        shift_d    = shift_lat_q;
        prop_out_d = prop_q;
        count_d    = '0;
        state_d    = (len_q == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        // Bubbles keep a/b at their last values; d is only nonzero on the preload beat.
        d_d = '0;
        if (data_valid && data_ready) begin
          a_d     = data_a;
          b_d     = data_b;
          valid_d = 1'b1;
          count_d = count_q + CNT_ONE;
          if (count_d == {1'b0, len_q}) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    if (RST) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      shift_lat_q <= '0;
      d_lat_q     <= '0;
      prop_q      <= 1'b0;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      valid_q     <= 1'b0;
      shift_q     <= '0;
      prop_out_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      shift_lat_q <= shift_lat_d;
      d_lat_q     <= d_lat_d;
      prop_q      <= prop_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      valid_q     <= valid_d;
      shift_q     <= shift_d;
      prop_out_q  <= prop_out_d;
      done_q      <= done_d;
    end
  end

  assign io_in_a1                 = a_q;
  assign io_in_b1                 = b_q;
  assign io_in_d1                 = d_q;
  assign io_in_valid1             = valid_q;
  assign io_in_control_shift1     = shift_q;
  assign io_in_control_propagate1 = prop_out_q;
  assign tile_done                = done_q;

endmodule
